uart_tx_sequencer: RTL and testbench

Upstream message source for the UART transmitter. Latches a message of up to NUM_BYTES bytes on a start pulse and hands the bytes, LSB-byte first, to the transmitter one at a time over its Tx_DATA / Tx_WR / Tx_BUSY handshake. An inter-byte gap follows each byte, and the block can optionally loop the message. Outputs connect directly to the transmitter's Tx_EN, Tx_WR and Tx_DATA inputs; its Tx_BUSY feeds back into this block.

---
 rtl/uart_tx_sequencer.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Message source for a UART transmitter: latches up to NUM_BYTES bytes on start and
// writes them LSB-byte first over the Tx_WR/Tx_BUSY handshake, with gap, repeat and abort.
module uart_tx_sequencer #(
   parameter int NUM_BYTES   = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int ACK_TIMEOUT = 64,
   localparam int LEN_W = $clog2(NUM_BYTES + 1),
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   repeat_en,
   input  logic [8*NUM_BYTES-1:0] msg_data,
   input  logic [LEN_W-1:0]       msg_len,
   input  logic                   Tx_BUSY,
   output logic                   Tx_EN,
   output logic                   Tx_WR,
   output logic [7:0]             Tx_DATA,
   output logic [IDX_W-1:0]       byte_idx,
   output logic                   seq_busy,
   output logic                   seq_done,
   output logic                   seq_err
);

   localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(NUM_BYTES);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WRITE     = 3'd1;
   localparam logic [2:0] S_WAIT_ACK  = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d, start_len;
   logic [7:0]       msg_q [NUM_BYTES];
   logic [7:0]       msg_d [NUM_BYTES];
   logic             tx_en_q, tx_en_d;
   logic             tx_wr_q, tx_wr_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             more_bytes;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      len_d     = len_q;
      msg_d     = msg_q;
      tx_en_d   = tx_en_q;
      tx_wr_d   = 1'b0;
      tx_data_d = tx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      start_len  = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
      more_bytes = (LEN_W'(idx_q) + LEN_W'(1)) < len_q;

      // abort wins over every other transition outside IDLE
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         tx_en_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_BYTES; i++) msg_d[i] = msg_data[8*i +: 8];
                  len_d = start_len;
                  err_d = 1'b0;
                  idx_d = '0;
                  if (start_len == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = S_WRITE;
                     tx_en_d = 1'b1;
                     busy_d  = 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (!Tx_BUSY) begin
                  tx_wr_d   = 1'b1;
                  tx_data_d = msg_q[idx_q];
                  cnt_d     = CNT_W'(1);
                  state_d   = S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (Tx_BUSY) begin
                  state_d = S_WAIT_DONE;
               end else if (cnt_q >= ACK_LIM) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                  tx_en_d = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!Tx_BUSY) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LOAD;
               end
            end
            S_GAP: begin
               if (cnt_q == '0) begin
                  if (more_bytes) begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = S_WRITE;
                  end else if (repeat_en) begin
                     done_d  = 1'b1;
                     idx_d   = '0;
                     state_d = S_WRITE;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                     tx_en_d = 1'b0;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         tx_en_q   <= tx_en_d;
         tx_wr_q   <= tx_wr_d;
         tx_data_q <= tx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // message storage needs no reset: it is only read after a start has loaded it
   always_ff @(posedge clk) begin
      msg_q <= msg_d;
   end

   assign Tx_EN    = tx_en_q;
   assign Tx_WR    = tx_wr_q;
   assign Tx_DATA  = tx_data_q;
   assign byte_idx = idx_q;
   assign seq_busy = busy_q;
   assign seq_done = done_q;
   assign seq_err  = err_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: a transmitter model drives Tx_BUSY, a
// reference model queues expected bytes/done pulses, a monitor pops and compares.
module tb_uart_tx_sequencer;
   localparam int NB = 4, GAP = 16, ACKT = 64, BUSY_LEN = 10;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, repeat_en = 1'b0;
   logic [8*NB-1:0] msg_data = '0;
   logic [2:0] msg_len = '0;
   logic Tx_BUSY = 1'b0;
   logic Tx_EN, Tx_WR, seq_busy, seq_done, seq_err;
   logic [7:0] Tx_DATA;
   logic [1:0] byte_idx;

   uart_tx_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKT)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .repeat_en(repeat_en),
      .msg_data(msg_data), .msg_len(msg_len), .Tx_BUSY(Tx_BUSY), .Tx_EN(Tx_EN),
      .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .byte_idx(byte_idx), .seq_busy(seq_busy),
      .seq_done(seq_done), .seq_err(seq_err));

   always #5 clk = ~clk;

   int cyc = 0;
   logic busy_at_edge = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      busy_at_edge <= Tx_BUSY;
   end

   int n_checks = 0, n_fail = 0;
   logic [7:0] exp_byte[$];
   int exp_idx[$];
   int exp_done = 0;
   logic [7:0] ref_msg[NB];
   int ref_len = 0;
   bit first_wr = 1'b1;
   int last_fall = -1000, last_wr = -1000;
   bit prev_wr = 1'b0, prev_done = 1'b0;
   int tx_mode = 0;  // 0: modelled transmitter, 1: busy tied low, 2: busy tied high

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endfunction

   function automatic void push_pass();
      for (int i = 0; i < ref_len; i++) begin
         exp_byte.push_back(ref_msg[i]);
         exp_idx.push_back(i);
      end
   endfunction

   function automatic void flush();
      exp_byte.delete();
      exp_idx.delete();
      exp_done = 0;
      first_wr = 1'b1;
   endfunction

   // Transmitter: busy for BUSY_LEN cycles, starting one cycle after each Tx_WR
   int busy_left = 0;
   bit pend = 1'b0, nb_busy;
   always @(negedge clk) begin
      if (tx_mode != 0) begin
         Tx_BUSY = (tx_mode == 2);
         busy_left = 0;
         pend = 1'b0;
      end else begin
         if (busy_left > 0) busy_left--;
         else if (pend) begin
            pend = 1'b0;
            busy_left = BUSY_LEN;
         end
         if (Tx_WR) pend = 1'b1;
         nb_busy = (busy_left > 0);
         if (Tx_BUSY && !nb_busy) last_fall = cyc + 1;
         Tx_BUSY = nb_busy;
      end
   end

   // Monitor
   logic [7:0] eb;
   int ei;
   always @(negedge clk) begin
      if (Tx_WR) begin
         check("wr_back_to_back", int'(prev_wr), 0);
         check("wr_while_busy", int'(busy_at_edge), 0);
         if (exp_byte.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_wr: got data 0x%0h, expected no write at cycle %0d", Tx_DATA, cyc);
         end else begin
            eb = exp_byte.pop_front();
            ei = exp_idx.pop_front();
            check("tx_data", int'(Tx_DATA), int'(eb));
            check("byte_idx", int'(byte_idx), ei);
            if (!first_wr && tx_mode == 0 && last_fall > last_wr)
               check("gap_spacing", cyc - last_fall, GAP + 1);
            first_wr = 1'b0;
            if (exp_byte.size() == 0) begin
               exp_done++;
               if (repeat_en) push_pass();
            end
         end
         last_wr = cyc;
      end
      prev_wr = Tx_WR;
      if (seq_done) begin
         check("done_width", int'(prev_done), 0);
         if (exp_done == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got seq_done=1, expected 0 at cycle %0d", cyc);
         end else exp_done--;
      end
      prev_done = seq_done;
   end

   task automatic do_start(input logic [31:0] data, input int len);
      @(negedge clk);
      msg_data = data;
      msg_len = 3'(len);
      start = 1'b1;
      ref_len = (len > NB) ? NB : len;
      for (int i = 0; i < NB; i++) ref_msg[i] = data[8*i +: 8];
      if (ref_len == 0) exp_done++;
      else begin
         push_pass();
         first_wr = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while (seq_busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_reached"}, int'(n < bound), 1);
      repeat (3) @(negedge clk);
      check({name, "_bytes_left"}, exp_byte.size(), 0);
      check({name, "_done_left"}, exp_done, 0);
   endtask

   task automatic wait_writes(input int count, input int bound);
      int n = 0, t = 0;
      while (n < count && t < bound) begin
         @(negedge clk);
         t++;
         if (Tx_WR) n++;
      end
      check("writes_seen", n, count);
   endtask

   initial begin
      int t;
      logic [31:0] rd;
      int rl;
      repeat (3) @(negedge clk);
      check("reset_state", int'({Tx_EN, Tx_WR, Tx_DATA, byte_idx, seq_busy, seq_done, seq_err}), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // basic pass
      do_start(32'h44332211, 4);
      check("start_busy", int'({seq_busy, Tx_EN, Tx_WR}), 3'b110);
      @(negedge clk);
      check("first_wr_latency", int'(Tx_WR), 1);
      t = 0;
      while (!seq_done && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("basic_done_seen", int'(seq_done), 1);
      check("basic_end_busy_en", int'({seq_busy, Tx_EN}), 0);
      wait_idle("basic", 50);
      check("data_held_idle", int'(Tx_DATA), 8'h44);

      // zero and oversize lengths
      do_start(32'hCAFEF00D, 0);
      check("len0_done", int'({seq_done, seq_busy, Tx_EN}), 3'b100);
      repeat (20) @(negedge clk);
      wait_idle("len0", 10);
      do_start(32'hDEADBEEF, 7);
      wait_idle("len7", 600);

      // randomized messages
      for (int k = 0; k < 6; k++) begin
         rd = $urandom;
         rl = $urandom_range(0, 7);
         do_start(rd, rl);
         wait_idle("rand", 600);
      end

      // repeat then abort in the third WAIT_DONE
      repeat_en = 1'b1;
      do_start(32'h0000BBAA, 2);
      wait_writes(3, 500);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_outputs", int'({Tx_EN, seq_busy, Tx_WR, seq_done, seq_err}), 0);
      flush();
      repeat_en = 1'b0;
      repeat (60) @(negedge clk);
      check("abort_stays_idle", int'({Tx_EN, seq_busy}), 0);

      // ack timeout
      tx_mode = 1;
      do_start(32'h00C3B2A1, 3);
      t = 0;
      while (!seq_err && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("timeout_edge", cyc - last_wr, ACKT);
      check("timeout_outputs", int'({seq_err, seq_busy, Tx_EN, seq_done}), 4'b1000);
      check("timeout_one_write", exp_byte.size(), 2);
      flush();
      repeat (5) @(negedge clk);
      tx_mode = 0;
      repeat (2) @(negedge clk);
      do_start(32'h0000005A, 1);
      check("err_cleared", int'(seq_err), 0);
      wait_idle("after_err", 200);

      // busy hold-off and ignored second start
      tx_mode = 2;
      @(negedge clk);
      do_start(32'h000C0B0A, 3);
      t = 0;
      repeat (4) begin
         @(negedge clk);
         if (Tx_WR) t++;
      end
      check("holdoff_no_wr", t, 0);
      check("holdoff_busy", int'(seq_busy), 1);
      @(negedge clk);
      msg_data = 32'hFFFFFFFF;
      msg_len = 3'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tx_mode = 0;
      wait_idle("holdoff", 600);

      // reset in the middle of a sequence
      do_start(32'h55667788, 4);
      wait_writes(2, 300);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midseq_reset", int'({Tx_EN, Tx_WR, Tx_DATA, byte_idx, seq_busy, seq_done, seq_err}), 0);
      flush();
      reset = 1'b1;
      repeat (80) @(negedge clk);
      check("post_reset_idle", int'({Tx_EN, seq_busy}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
